// File: rtl/mc_control.sv
// rtl/mc_control.sv - multicycle MIPS main-control FSM with brn support, memory stall timeout and sticky trap
module mc_control #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic       brnin,
    input  logic       nflag,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       aluop1,
    output logic       aluop0,
    output logic [1:0] pcsource,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        MEMADR = 4'd3,
        MEMRD  = 4'd4,
        MEMWB  = 4'd5,
        MEMWR  = 4'd6,
        REX    = 4'd7,
        RWB    = 4'd8,
        BEQ    = 4'd9,
        JMP    = 4'd10,
        BRN    = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

    state_t           cur;
    logic [CNT_W-1:0] cnt;
    logic             stall_timeout;

    assign stall_timeout = !mem_ready && (cnt == CNT_MAX);

    // The counter defaults to zero, so it is cleared on every entry into a wait state
    // and only survives while the FSM is stalling in one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= IDLE;
            cnt <= '0;
        end else begin
            cnt <= '0;
            case (cur)
                IDLE:   cur <= FETCH;
                FETCH, MEMRD, MEMWR: begin
                    if (mem_ready) begin
                        cur <= (cur == FETCH) ? DECODE : (cur == MEMRD) ? MEMWB : FETCH;
                    end else if (stall_timeout) begin
                        cur <= TRAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_RTYPE:      cur <= REX;
                        OP_LW, OP_SW:  cur <= MEMADR;
                        OP_BEQ:        cur <= BEQ;
                        OP_J:          cur <= JMP;
                        default:       cur <= TRAP;
                    endcase
                end
                MEMADR: cur <= (op == OP_LW) ? MEMRD : MEMWR;
                REX:    cur <= brnin ? BRN : RWB;
                MEMWB, RWB, BEQ, JMP, BRN: cur <= FETCH;
                TRAP:   cur <= TRAP;
                default: cur <= TRAP;
            endcase
        end
    end

    // Outputs decode from state; pcwrite/irwrite in FETCH and pcwrite in BRN also see inputs.
    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop1      = 1'b0;
        aluop0      = 1'b0;
        pcsource    = 2'b00;
        trap        = 1'b0;
        case (cur)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            DECODE: alusrcb = 2'b11;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            REX: begin
                alusrca = 1'b1;
                aluop1  = 1'b1;
            end
            RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                aluop1   = 1'b1;
            end
            BRN: begin
                pcsource = 2'b11;
                pcwrite  = nflag;
            end
            BEQ: begin
                alusrca     = 1'b1;
                aluop0      = 1'b1;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            TRAP:    trap = 1'b1;
            default: ;
        endcase
    end

    assign state = cur;

    logic unused_zero;
    assign unused_zero = zero;

endmodule

// File: tb/tb_mc_control.sv
// tb/tb_mc_control.sv - directed self-checking bench for mc_control
module tb_mc_control;

    localparam int WAIT_MAX = 15;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       brnin, nflag, zero, mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, aluop1, aluop0, trap;
    logic [1:0] alusrcb, pcsource;
    logic [3:0] state;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mc_control #(.WAIT_MAX(WAIT_MAX), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .brnin(brnin), .nflag(nflag), .zero(zero),
        .mem_ready(mem_ready), .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg),
        .regdst(regdst), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop1(aluop1), .aluop0(aluop0), .pcsource(pcsource), .trap(trap), .state(state)
    );

    // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,regwrite,
    //  alusrca,alusrcb[1:0],aluop1,aluop0,pcsource[1:0],trap}
    function automatic logic [16:0] outs();
        return {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst,
                regwrite, alusrca, alusrcb, aluop1, aluop0, pcsource, trap};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; op = 6'b000000; brnin = 1'b0; nflag = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("reset_state", state, 4'd0);
        chk("reset_outs", outs(), 17'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        chk("idle_state", state, 4'd0);

        // R-type
        step(); chk("r_fetch_state", state, 4'd1);
        chk("r_fetch_outs", outs(), 17'b1_0_0_1_0_1_0_0_0_0_01_0_0_00_0);
        step(); chk("r_decode_state", state, 4'd2);
        chk("r_decode_outs", outs(), 17'b0_0_0_0_0_0_0_0_0_0_11_0_0_00_0);
        step(); chk("r_rex_state", state, 4'd7);
        chk("r_rex_outs", outs(), 17'b0_0_0_0_0_0_0_0_0_1_00_1_0_00_0);
        step(); chk("r_rwb_state", state, 4'd8);
        chk("r_rwb_outs", outs(), 17'b0_0_0_0_0_0_0_1_1_0_00_1_0_00_0);
        step(); chk("r_back_fetch", state, 4'd1);

        // lw with three stall cycles in MEMRD
        op = 6'b100011;
        step(); chk("lw_decode", state, 4'd2);
        step(); chk("lw_memadr", state, 4'd3);
        chk("lw_memadr_outs", outs(), 17'b0_0_0_0_0_0_0_0_0_1_10_0_0_00_0);
        step(); chk("lw_memrd", state, 4'd4);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            chk("lw_memrd_hold_state", state, 4'd4);
            chk("lw_memrd_outs", outs(), 17'b0_0_1_1_0_0_0_0_0_0_00_0_0_00_0);
            step();
        end
        chk("lw_memwb", state, 4'd5);
        chk("lw_memwb_outs", outs(), 17'b0_0_0_0_0_0_1_0_1_0_00_0_0_00_0);
        step(); chk("lw_back_fetch", state, 4'd1);

        // brn taken, then not taken
        op = 6'b000000; brnin = 1'b1; nflag = 1'b1;
        step(); step(); chk("brn_rex", state, 4'd7);
        step(); chk("brn_state", state, 4'd11);
        chk("brn_taken_outs", outs(), 17'b1_0_0_0_0_0_0_0_0_0_00_0_0_11_0);
        nflag = 1'b0; #1;
        chk("brn_mealy_pcwrite", pcwrite, 1'b0);
        @(negedge clk); chk("brn_after", state, 4'd1);
        step(); step(); step(); chk("brn_nt_state", state, 4'd11);
        chk("brn_nt_outs", outs(), 17'b0_0_0_0_0_0_0_0_0_0_00_0_0_11_0);
        brnin = 1'b0;
        step(); chk("brn_nt_after", state, 4'd1);

        // beq and j
        op = 6'b000100;
        step(); step(); chk("beq_state", state, 4'd9);
        chk("beq_outs", outs(), 17'b0_1_0_0_0_0_0_0_0_1_00_0_1_01_0);
        step(); chk("beq_after", state, 4'd1);
        op = 6'b000010;
        step(); step(); chk("j_state", state, 4'd10);
        chk("j_outs", outs(), 17'b1_0_0_0_0_0_0_0_0_0_00_0_0_10_0);
        step(); chk("j_after", state, 4'd1);

        // bad opcode -> sticky trap
        op = 6'b111111;
        step(); step(); chk("trap_state", state, 4'd12);
        chk("trap_outs", outs(), 17'h1);
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            step();
            chk("trap_hold", {state, trap}, {4'd12, 1'b1});
        end
        #2 rst_n = 1'b0; #1;
        chk("trap_reset", {state, trap}, {4'd0, 1'b0});
        @(negedge clk); rst_n = 1'b1;

        // fetch timeout after WAIT_MAX+1 stalled cycles
        mem_ready = 1'b0; op = 6'b000000;
        step(); chk("to_fetch", state, 4'd1);
        chk("to_fetch_noir", {irwrite, pcwrite}, 2'b00);
        for (int i = 0; i < WAIT_MAX; i++) step();
        chk("to_still_fetch", state, 4'd1);
        step(); chk("to_trap", {state, trap}, {4'd12, 1'b1});
        #2 rst_n = 1'b0; #1;
        chk("to_reset", state, 4'd0);
        @(negedge clk); rst_n = 1'b1;

        // mem_ready on the last allowed cycle wins
        step(); chk("edge_fetch", state, 4'd1);
        for (int i = 0; i < WAIT_MAX; i++) step();
        mem_ready = 1'b1; #1;
        chk("edge_irwrite", {irwrite, pcwrite}, 2'b11);
        op = 6'b101011;
        @(negedge clk); chk("edge_decode", {state, trap}, {4'd2, 1'b0});

        // sw, then async reset mid-MEMWR
        step(); chk("sw_memadr", state, 4'd3);
        mem_ready = 1'b0;
        step(); chk("sw_memwr", state, 4'd6);
        chk("sw_memwr_outs", outs(), 17'b0_0_1_0_1_0_0_0_0_0_00_0_0_00_0);
        #2 rst_n = 1'b0; #1;
        chk("sw_reset_memwrite", memwrite, 1'b0);
        chk("sw_reset_state", state, 4'd0);
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1;
        step(); chk("restart_fetch", state, 4'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
